// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and defaults for the mem_arbiter slice.
//   state_t : arbiter FSM encoding (IDLE=0, ISSUE=1, RESP=2)
//   grant_t : requester index (FETCH=0, DATA=1)
//   DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_t;

  // True for every state in which an access is in flight.
  function automatic logic state_is_busy(input state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch port, the load/store port and the RAM command port
// of mem_arbiter.
//   Fetch : i_req, i_addr -> i_rdata, i_ack
//   Data  : d_req, d_we, d_addr, d_wdata, d_wmask -> d_rdata, d_ack
//   RAM   : mem_en, mem_wmask, mem_addr, mem_wdata -> mem_rdata
//   Status: busy
// Handshake: a requester raises req with stable address/data and keeps it
// high until it sees a one-cycle ack; req still high in the cycle after
// ack is a new request. The RAM is single-port synchronous: a command is
// taken when mem_en=1 and read data appears the following cycle.
// Modports:
//   master : requesters and the RAM model (environment side)
//   slave  : the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_wmask;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic [MASK_W-1:0] mem_wmask;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack,
    input  mem_en, mem_wmask, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack,
    output mem_en, mem_wmask, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant
// Combinational tie-break between the fetch and data requesters.
// Build option MEM_ARB_RR_EN:
//   defined   : round-robin, a tie goes to the requester not granted last;
//               last_nxt is the pointer value to register on a grant.
//   undefined : fixed priority, DATA wins every tie; no pointer exists.
// Ports:
//   i_req, d_req : raw requests
//   take         : (RR only) a grant is being taken this cycle
//   last_q       : (RR only) registered last-grant pointer
//   last_nxt     : (RR only) next pointer value
//   any_req      : at least one request is present
//   grant        : winner index
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  logic   take,
  input  grant_t last_q,
  output grant_t last_nxt,
`endif
  output logic   any_req,
  output grant_t grant
);

  always_comb begin
    any_req = i_req | d_req;
    grant   = FETCH;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) begin
      // Alternate on a tie: whoever was served last yields.
      grant = (last_q == FETCH) ? DATA : FETCH;
    end else if (d_req) begin
      grant = DATA;
    end else begin
      grant = FETCH;
    end
    // The pointer follows every grant, not only ties.
    last_nxt = take ? grant : last_q;
`else
    grant = d_req ? DATA : FETCH;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous RAM between an instruction-fetch port
// and a load/store port. Every access takes exactly three cycles:
//   IDLE  : requests sampled, winner's command latched
//   ISSUE : mem_en=1, command presented to the RAM
//   RESP  : RAM data returned on the granted port with a one-cycle ack
// Build option MEM_ARB_RR_EN selects round-robin tie-breaking; without it
// DATA has fixed priority (see mem_arb_grant).
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-high reset; aborts any access in flight
//   bus       : mem_arbiter_if.slave (fetch, data and RAM ports, busy)
//   state_dbg : current FSM state
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output state_t        state_dbg
);

  localparam int MASK_W = DATA_W / 8;

  state_t            state_q;
  state_t            state_d;
  logic              take;

  grant_t            grant;
  logic              any_req;
  grant_t            grant_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_ack_int;
  logic              d_ack_int;

`ifdef MEM_ARB_RR_EN
  grant_t            last_q;
  grant_t            last_nxt;
`endif

  mem_arb_grant u_grant (
    .i_req    (bus.i_req),
    .d_req    (bus.d_req),
`ifdef MEM_ARB_RR_EN
    .take     (take),
    .last_q   (last_q),
    .last_nxt (last_nxt),
`endif
    .any_req  (any_req),
    .grant    (grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. Requests are only looked at in IDLE, so a requester that
  // drops req after being granted does not disturb the access.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          take    = 1'b1;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch and returned-data holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= FETCH;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q    <= DATA;
`endif
    end else begin
`ifdef MEM_ARB_RR_EN
      last_q <= last_nxt;
`endif
      if (take) begin
        grant_q <= grant;
        if (grant == DATA) begin
          we_q    <= bus.d_we;
          addr_q  <= bus.d_addr;
          wdata_q <= bus.d_wdata;
          wmask_q <= bus.d_we ? bus.d_wmask : '0;
        end else begin
          we_q    <= 1'b0;
          addr_q  <= bus.i_addr;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
      if (state_q == RESP) begin
        if (grant_q == FETCH) begin
          i_rdata_q <= bus.mem_rdata;
        end else if (!we_q) begin
          d_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  // Acks and the RAM strobe are gated by rst so an aborted access never
  // completes and an aborted store never reaches the RAM.
  always_comb begin
    i_ack_int = (state_q == RESP) && (grant_q == FETCH) && !rst;
    d_ack_int = (state_q == RESP) && (grant_q == DATA) && !rst;
  end

  // The RAM delivers data during RESP, so the ack cycle forwards it
  // directly; the holding registers cover every other cycle.
  always_comb begin
    bus.mem_en    = (state_q == ISSUE) && !rst;
    bus.mem_wmask = bus.mem_en ? wmask_q : '0;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.i_ack     = i_ack_int;
    bus.d_ack     = d_ack_int;
    bus.i_rdata   = i_ack_int ? bus.mem_rdata : i_rdata_q;
    bus.d_rdata   = (d_ack_int && !we_q) ? bus.mem_rdata : d_rdata_q;
    bus.busy      = state_is_busy(state_q);
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a synchronous RAM model. Drivers push
// expected {port, rdata} entries into exp_q; a negedge monitor pops one on
// every ack and compares. Cycle-exact timing is checked in run_single.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic   clk;
  logic   rst;
  state_t state_dbg;
  int     n_tests;
  int     n_fail;
  int     cyc;

  logic [DW:0] exp_q[$];

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] ram_merge;

  always_comb begin
    ram_merge = ram[bus.mem_addr];
    for (int b = 0; b < DW / 8; b++) begin
      if (bus.mem_wmask[b]) ram_merge[8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wmask != '0) ram[bus.mem_addr] <= ram_merge;
      else                     ram_rdata <= ram[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = ram_rdata;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_mem_en;
  logic [DW:0] sb_e;

  initial prev_mem_en = 1'b0;

  always @(negedge clk) begin
    if (bus.i_ack || bus.d_ack) check("ack_exclusive", {63'd0, bus.i_ack & bus.d_ack}, 64'd0);
    if (bus.i_ack) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected_i_ack: got i_rdata 0x%0h expected no ack", bus.i_rdata);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_fetch", {31'd0, 1'b0, bus.i_rdata}, {31'd0, sb_e});
      end
    end
    if (bus.d_ack) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected_d_ack: got d_rdata 0x%0h expected no ack", bus.d_rdata);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_data", {31'd0, 1'b1, bus.d_rdata}, {31'd0, sb_e});
      end
    end
    if (bus.mem_en) check("mem_en_not_consecutive", {63'd0, prev_mem_en}, 64'd0);
    prev_mem_en = bus.mem_en;
  end

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_wmask = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated access with cycle-exact checks; starts and ends at a negedge.
  task automatic run_single(input logic is_data, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [3:0] wmask,
                            input logic [DW-1:0] exp_data, input string tag);
    logic [3:0] exp_mask;
    exp_mask = (is_data && we) ? wmask : 4'd0;
    exp_q.push_back({is_data, exp_data});
    if (is_data) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
      bus.d_wdata = wdata; bus.d_wmask = wmask;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    @(negedge clk);
    check({tag, "_issue_mem_en"}, {63'd0, bus.mem_en}, 64'd1);
    check({tag, "_issue_busy"}, {63'd0, bus.busy}, 64'd1);
    check({tag, "_issue_addr"}, {56'd0, bus.mem_addr}, {56'd0, addr});
    check({tag, "_issue_wmask"}, {60'd0, bus.mem_wmask}, {60'd0, exp_mask});
    if (is_data && we) check({tag, "_issue_wdata"}, {32'd0, bus.mem_wdata}, {32'd0, wdata});
    check({tag, "_issue_no_ack"}, {62'd0, bus.i_ack, bus.d_ack}, 64'd0);
    @(negedge clk);
    check({tag, "_resp_ack"}, {62'd0, bus.i_ack, bus.d_ack}, is_data ? 64'd1 : 64'd2);
    check({tag, "_resp_mem_en"}, {63'd0, bus.mem_en}, 64'd0);
    clear_inputs();
    @(negedge clk);
    check({tag, "_done_busy"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_done_no_ack"}, {62'd0, bus.i_ack, bus.d_ack}, 64'd0);
  endtask

  int f_ack_cyc[8];

  // Holds i_req for n back-to-back fetches, dropping it after the last ack.
  task automatic drive_fetch(input logic [AW-1:0] addr, input int n);
    int got;
    int budget;
    got = 0; budget = 0;
    bus.i_req = 1'b1; bus.i_addr = addr;
    while (got < n && budget < 100) begin
      @(negedge clk);
      budget++;
      if (bus.i_ack) begin
        f_ack_cyc[got] = cyc;
        got++;
      end
    end
    bus.i_req = 1'b0;
    if (got < n) check("fetch_ack_count_timeout", 64'(got), 64'(n));
  endtask

  // Holds d_req for n back-to-back loads/stores.
  task automatic drive_data(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [3:0] wmask, input int n);
    int got;
    int budget;
    got = 0; budget = 0;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
    bus.d_wdata = wdata; bus.d_wmask = wmask;
    while (got < n && budget < 100) begin
      @(negedge clk);
      budget++;
      if (bus.d_ack) got++;
    end
    bus.d_req = 1'b0;
    if (got < n) check("data_ack_count_timeout", 64'(got), 64'(n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int i = 0; i < 256; i++) ram[i] <= '0;
    ram_rdata <= '0;
    ram[5]    <= 32'h0010_0093;
    ram[6]    <= 32'h0020_0113;

    apply_reset();

    // Reset state.
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mem_en", {63'd0, bus.mem_en}, 64'd0);
    check("rst_acks", {62'd0, bus.i_ack, bus.d_ack}, 64'd0);
    check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
    check("rst_mem_cmd", {28'd0, bus.mem_wmask, bus.mem_addr, 24'd0}, 64'd0);
    check("rst_state", {62'd0, state_dbg}, 64'd0);

    // Single fetch from word 5.
    run_single(1'b0, 1'b0, 8'h05, 32'h0, 4'h0, 32'h0010_0093, "fetch5");
    check("fetch5_rdata_held", {32'd0, bus.i_rdata}, 64'h0010_0093);

    // Partial store then load-back; store ack leaves d_rdata at 0.
    run_single(1'b1, 1'b1, 8'h10, 32'hA5A5_A5A5, 4'b0011, 32'h0, "store10");
    run_single(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 32'h0000_A5A5, "load10");
    check("load10_rdata_held", {32'd0, bus.d_rdata}, 64'h0000_A5A5);

    // Reset during ISSUE of a load aborts it.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10;
    @(negedge clk);
    check("abort_issue_mem_en", {63'd0, bus.mem_en}, 64'd1);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    check("abort_no_d_ack", {63'd0, bus.d_ack}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_d_rdata", {32'd0, bus.d_rdata}, 64'd0);
    check("abort_i_rdata", {32'd0, bus.i_rdata}, 64'd0);
    rst = 1'b0;
    run_single(1'b0, 1'b0, 8'h05, 32'h0, 4'h0, 32'h0010_0093, "after_abort");

    // Both requesters held together.
    apply_reset();
`ifdef MEM_ARB_RR_EN
    exp_q.push_back({1'b0, 32'h0010_0093});
    exp_q.push_back({1'b1, 32'h0000_A5A5});
    exp_q.push_back({1'b0, 32'h0010_0093});
    exp_q.push_back({1'b1, 32'h0000_A5A5});
    fork
      drive_fetch(8'h05, 2);
      drive_data(1'b0, 8'h10, 32'h0, 4'h0, 2);
    join
`else
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 32'h0000_A5A5});
    exp_q.push_back({1'b0, 32'h0010_0093});
    fork
      drive_fetch(8'h05, 1);
      drive_data(1'b0, 8'h10, 32'h0, 4'h0, 4);
    join
`endif
    repeat (2) @(negedge clk);
    check("tie_all_acks_seen", 64'(exp_q.size()), 64'd0);

    // Five back-to-back fetches: one ack every 3 cycles.
    for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 32'h0020_0113});
    drive_fetch(8'h06, 5);
    for (int k = 1; k < 5; k++) check("fetch_ack_spacing", 64'(f_ack_cyc[k] - f_ack_cyc[k-1]), 64'd3);

    repeat (3) @(negedge clk);
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width (256-word memory).
REQ-002 SHALL have parameter DATA_W, default 32, data width; the byte-mask width SHALL be DATA_W/8.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req  in  1  instruction-fetch read request, held high until i_ack.
REQ-006 SHALL have port i_addr  in  ADDR_W  fetch word address, held stable until i_ack.
REQ-007 SHALL have port i_rdata  out  DATA_W  fetched word, valid in i_ack cycle.
REQ-008 SHALL have port i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_req  in  1  load/store request, held high until d_ack.
REQ-010 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-011 SHALL have port d_addr  in  ADDR_W  data word address.
REQ-012 SHALL have port d_wdata  in  DATA_W  store data.
REQ-013 SHALL have port d_wmask  in  DATA_W/8  store byte enables.
REQ-014 SHALL have port d_rdata  out  DATA_W  load data, valid in d_ack cycle.
REQ-015 SHALL have port d_ack  out  1  one-cycle load/store completion pulse.
REQ-016 SHALL have port mem_en  out  1  memory access strobe, single-port synchronous RAM.
REQ-017 SHALL have port mem_wmask  out  DATA_W/8  byte write enables; all-zero means read.
REQ-018 SHALL have port mem_addr, mem_wdata  out  ADDR_W, DATA_W  registered command to the RAM.
REQ-019 SHALL have port mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en.
REQ-020 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement an FSM with states IDLE, ISSUE and RESP, and SHALL visit them in order IDLE->ISSUE->RESP->IDLE.
REQ-022 SHALL sample i_req and d_req only in IDLE; with neither request asserted it SHALL stay in IDLE.
REQ-023 SHALL, in IDLE when at least one request is asserted, latch the grant, address, wdata and mask of the winner and enter ISSUE.
REQ-024 SHALL drive mem_en=1 for exactly the ISSUE cycle and 0 in every other cycle.
REQ-025 SHALL drive mem_wmask = d_wmask for a granted store, and 0 for a load or fetch.
REQ-026 SHALL, in RESP, register mem_rdata into the granted port's rdata and pulse that port's ack for exactly one cycle.
REQ-027 SHALL pulse d_ack for a store without updating d_rdata.
REQ-028 SHALL give a fixed latency of request sampled in IDLE at cycle N -> mem_en at N+1 -> ack at N+2, i.e. 3 cycles per access.
REQ-029 SHALL hold each rdata output at its last loaded value between acks.
REQ-030 SHALL never assert both acks in the same cycle.
REQ-031 SHALL treat a requester still asserting req in the cycle after its ack as a new request, so back-to-back accesses are legal.
REQ-032 SHALL resolve the case where both requests are asserted in IDLE according to REQ-036/037.
REQ-033 SHALL ignore a request that drops before ack (protocol violation) once granted, and SHALL still complete the access.

Reset
REQ-034 SHALL, when rst=1 at a clock edge, force state=IDLE; all outputs SHALL be 0 in the next cycle, and the last-grant pointer SHALL be set to DATA.
REQ-035 SHALL, when rst is asserted during ISSUE or RESP, abort the access; no ack SHALL be emitted and the rdata outputs SHALL be 0 in the next cycle.

Configuration
REQ-036 SHALL, when MEM_ARB_RR_EN is defined, arbitrate simultaneous requests round-robin: the grant goes to the requester not granted last, and the first tie after reset goes to FETCH.
REQ-037 SHALL, when MEM_ARB_RR_EN is undefined, use fixed priority with DATA winning every tie and omit the last-grant pointer.

Structure
REQ-038 SHALL place the state encoding (IDLE=0, ISSUE=1, RESP=2), the grant indices (FETCH=0, DATA=1) and default widths in package mem_arb_pkg.
REQ-039 SHALL put the tie-breaking logic, combinational and including the pointer update, in a single sub-module mem_arb_grant; the FSM and registers SHALL remain in mem_arbiter.

Verification
REQ-040 SHALL cover: i_req=1, i_addr=0x05, RAM[5]=0x00100093 -> mem_en at N+1, i_ack with i_rdata=0x00100093 at N+2, d_ack=0 throughout.
REQ-041 SHALL cover: store d_addr=0x10, d_wdata=0xA5A5A5A5, d_wmask=0b0011, then load 0x10 with prior RAM=0 -> mem_wmask=0b0011, and the load returns 0x0000A5A5.
REQ-042 SHALL cover: i_req and d_req both held for 4 accesses -> with MEM_ARB_RR_EN the grants are F,D,F,D; without it D,D,D,D and fetch starves.
REQ-043 SHALL cover: rst pulsed during the ISSUE of a load -> no d_ack, busy=0 and d_rdata=0 next cycle, and a subsequent request completes in 3 cycles.
REQ-044 SHALL cover: i_req held continuously for 5 fetches -> an i_ack every 3 cycles and mem_en never asserted in consecutive cycles.
